q_8_29_datapath: RTL and testbench

Q_8_29_DATAPATH -- requirements
Module: q_8_29_datapath

---
 rtl/q_8_29_datapath.sv | 89 ++++++++
 tb/tb_q_8_29_datapath.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/q_8_29_datapath.sv
// Datapath for the 8-state one-hot controller: A/B operand registers, pass counter C,
// carry flag E, completion pulse and a sticky flag for malformed decodes.
module q_8_29_datapath (
  input  logic       clk,
  input  logic       rst_b,
  input  logic [7:0] dec_in,
  input  logic [7:0] a_in,
  input  logic [7:0] b_in,
  output logic [7:0] a_out,
  output logic [7:0] b_out,
  output logic [3:0] c_out,
  output logic       F,
  output logic       E,
  output logic       done,
  output logic       err
);

  logic [7:0] a_q, a_d;
  logic [7:0] b_q, b_d;
  logic [3:0] c_q, c_d;
  logic       e_q, e_d;
  logic       done_q, done_d;
  logic       err_q, err_d;
  logic [8:0] sum;
  logic       legal;

  // Exactly one decode bit set: non-zero and clearing the lowest set bit leaves nothing.
  assign legal = (dec_in != 8'h00) && ((dec_in & (dec_in - 8'h01)) == 8'h00);
  assign sum   = {1'b0, a_q} + {1'b0, b_q};

  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    c_d    = c_q;
    e_d    = e_q;
    done_d = 1'b0;
    err_d  = err_q;
    if (!legal) begin
      err_d = 1'b1;
    end else begin
      done_d = dec_in[4] | dec_in[2] | dec_in[0];
      case (dec_in)
        8'h80: begin
          a_d = a_in;
          b_d = b_in;
          e_d = 1'b0;
        end
        8'h40: begin
          a_d = sum[7:0];
          e_d = sum[8];
        end
        8'h20: c_d = c_q + 4'h1;
        8'h10: a_d = {1'b0, a_q[7:1]};
        8'h08: b_d = b_q - 8'h01;
        8'h04: a_d = 8'h00;
        8'h02: a_d = a_q ^ b_q;
        8'h01: b_d = a_q;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      a_q    <= 8'h00;
      b_q    <= 8'h00;
      c_q    <= 4'h0;
      e_q    <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      a_q    <= a_d;
      b_q    <= b_d;
      c_q    <= c_d;
      e_q    <= e_d;
      done_q <= done_d;
      err_q  <= err_d;
    end
  end

  assign a_out = a_q;
  assign b_out = b_q;
  assign c_out = c_q;
  assign F     = a_q[7];
  assign E     = e_q;
  assign done  = done_q;
  assign err   = err_q;

endmodule

// File: tb/tb_q_8_29_datapath.sv
// Self-checking bench: directed vector table, hand-written corner sequences,
// then randomized decodes checked against an arithmetic reference model.
module tb_q_8_29_datapath;

  logic       clk;
  logic       rst_b;
  logic [7:0] dec_in, a_in, b_in;
  logic [7:0] a_out, b_out;
  logic [3:0] c_out;
  logic       F, E, done, err;

  int total = 0;
  int bad   = 0;

  // reference model state
  int ma, mb, mc, me, md, merr;

  typedef struct {
    logic       rst;
    logic [7:0] dec, a, b, ea, eb;
    logic [3:0] ec;
    logic       ee, ed;
  } vec_t;

  vec_t tbl[$];

  q_8_29_datapath dut (
    .clk(clk), .rst_b(rst_b), .dec_in(dec_in), .a_in(a_in), .b_in(b_in),
    .a_out(a_out), .b_out(b_out), .c_out(c_out), .F(F), .E(E),
    .done(done), .err(err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [7:0] ea, input logic [7:0] eb,
                         input logic [3:0] ec, input logic ee, input logic ed, input logic er);
    chk({tag, ".A"}, a_out, ea);
    chk({tag, ".B"}, b_out, eb);
    chk({tag, ".C"}, c_out, ec);
    chk({tag, ".E"}, E, ee);
    chk({tag, ".F"}, F, ea[7]);
    chk({tag, ".done"}, done, ed);
    chk({tag, ".err"}, err, er);
  endtask

  // Called at posedge+1; drives inputs away from the edge and returns at the next posedge+1.
  task automatic step(input logic [7:0] d, input logic [7:0] a, input logic [7:0] b);
    dec_in = d;
    a_in   = a;
    b_in   = b;
    @(posedge clk);
    #1;
  endtask

  // Mid-cycle asynchronous reset pulse; outputs must clear before any clock edge.
  task automatic do_reset();
    #3 rst_b = 1'b0;
    #1 chk_all("rst_async", 8'h00, 8'h00, 4'h0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1 chk_all("rst_held", 8'h00, 8'h00, 4'h0, 1'b0, 1'b0, 1'b0);
    rst_b = 1'b1;
    ma = 0; mb = 0; mc = 0; me = 0; md = 0; merr = 0;
  endtask

  function automatic vec_t mk(input logic r, input logic [7:0] d, input logic [7:0] a,
                              input logic [7:0] b, input logic [7:0] ea, input logic [7:0] eb,
                              input logic [3:0] ec, input logic ee, input logic ed);
    vec_t v;
    v.rst = r; v.dec = d; v.a = a; v.b = b; v.ea = ea; v.eb = eb;
    v.ec = ec; v.ee = ee; v.ed = ed;
    return v;
  endfunction

  // Behavioural model: classify the decode, then apply the state's rule arithmetically.
  task automatic model_step(input logic [7:0] d, input logic [7:0] a, input logic [7:0] b);
    int n, st, s;
    n = 0; st = 0;
    for (int k = 0; k < 8; k++) if (d[k]) begin n++; st = 7 - k; end
    md = 0;
    if (n != 1) begin
      merr = 1;
      return;
    end
    case (st)
      0: begin ma = a; mb = b; me = 0; end
      1: begin s = ma + mb; ma = s % 256; me = (s > 255) ? 1 : 0; end
      2: mc = (mc + 1) % 16;
      3: ma = ma / 2;
      4: mb = (mb + 255) % 256;
      5: ma = 0;
      6: ma = ma ^ mb;
      default: mb = ma;
    endcase
    if (st == 3 || st == 5 || st == 7) md = 1;
  endtask

  initial begin
    logic [7:0] d, sa, sb;
    logic [3:0] sc;
    logic       se;
    dec_in = 8'h00; a_in = 8'h00; b_in = 8'h00;
    rst_b = 1'b1;
    #1 rst_b = 1'b0;
    #1 chk_all("por", 8'h00, 8'h00, 4'h0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1 rst_b = 1'b1;

    // S_3 path
    tbl.push_back(mk(1'b0, 8'h80, 8'h50, 8'h40, 8'h50, 8'h40, 4'h0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 8'h40, 8'h00, 8'h00, 8'h90, 8'h40, 4'h0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 8'h20, 8'h00, 8'h00, 8'h90, 8'h40, 4'h1, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 8'h10, 8'h00, 8'h00, 8'h48, 8'h40, 4'h1, 1'b0, 1'b1));
    // S_5 path
    tbl.push_back(mk(1'b1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 4'h0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 8'h80, 8'h70, 8'h95, 8'h70, 8'h95, 4'h0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 8'h40, 8'h00, 8'h00, 8'h05, 8'h95, 4'h0, 1'b1, 1'b0));
    tbl.push_back(mk(1'b0, 8'h20, 8'h00, 8'h00, 8'h05, 8'h95, 4'h1, 1'b1, 1'b0));
    tbl.push_back(mk(1'b0, 8'h08, 8'h00, 8'h00, 8'h05, 8'h94, 4'h1, 1'b1, 1'b0));
    tbl.push_back(mk(1'b0, 8'h04, 8'h00, 8'h00, 8'h00, 8'h94, 4'h1, 1'b1, 1'b1));
    // S_7 path
    tbl.push_back(mk(1'b1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 4'h0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 8'h80, 8'h10, 8'h20, 8'h10, 8'h20, 4'h0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 8'h40, 8'h00, 8'h00, 8'h30, 8'h20, 4'h0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 8'h20, 8'h00, 8'h00, 8'h30, 8'h20, 4'h1, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 8'h08, 8'h00, 8'h00, 8'h30, 8'h1F, 4'h1, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 8'h02, 8'h00, 8'h00, 8'h2F, 8'h1F, 4'h1, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 8'h01, 8'h00, 8'h00, 8'h2F, 8'h2F, 4'h1, 1'b0, 1'b1));
    tbl.push_back(mk(1'b0, 8'h20, 8'h00, 8'h00, 8'h2F, 8'h2F, 4'h2, 1'b0, 1'b0));

    foreach (tbl[i]) begin
      if (tbl[i].rst) do_reset();
      else step(tbl[i].dec, tbl[i].a, tbl[i].b);
      $display("vec %0d rst=%0b dec=%02h A=%02h B=%02h C=%0h E=%0b F=%0b done=%0b",
               i, tbl[i].rst, tbl[i].dec, a_out, b_out, c_out, E, F, done);
      chk_all($sformatf("vec%0d", i), tbl[i].ea, tbl[i].eb, tbl[i].ec, tbl[i].ee, tbl[i].ed, 1'b0);
    end

    // Async reset while A=0x5A
    step(8'h80, 8'h5A, 8'h33);
    chk("pre_rst.A", a_out, 8'h5A);
    do_reset();
    $display("seq async_reset done");

    // Counter wrap: reach 0xF, then 16 more S_2 cycles step 0x0..0xF
    for (int i = 0; i < 15; i++) step(8'h20, 8'h00, 8'h00);
    chk("cwrap.start", c_out, 4'hF);
    for (int i = 0; i < 16; i++) begin
      step(8'h20, 8'h00, 8'h00);
      chk($sformatf("cwrap%0d", i), c_out, i);
    end
    $display("seq c_wrap C=%0h", c_out);

    // B decrement wrap
    step(8'h80, 8'h00, 8'h00);
    step(8'h08, 8'h00, 8'h00);
    chk("bwrap.B", b_out, 8'hFF);
    chk("bwrap.done", done, 1'b0);
    $display("seq b_wrap B=%02h", b_out);

    // Illegal decodes then legal S_2
    step(8'h80, 8'hC3, 8'h0D);
    step(8'h40, 8'h00, 8'h00);
    sa = a_out; sb = b_out; sc = c_out; se = E;
    chk("ill.pre_A", sa, 8'hD0);
    step(8'h00, 8'h11, 8'h22);
    chk_all("ill0", sa, sb, sc, se, 1'b0, 1'b1);
    step(8'h81, 8'h11, 8'h22);
    chk_all("ill1", sa, sb, sc, se, 1'b0, 1'b1);
    step(8'h20, 8'h00, 8'h00);
    chk_all("ill_resume", sa, sb, sc + 4'h1, se, 1'b0, 1'b1);
    step(8'h10, 8'h00, 8'h00);
    chk_all("ill_after", {1'b0, sa[7:1]}, sb, sc + 4'h1, se, 1'b1, 1'b1);
    $display("seq illegal err=%0b C=%0h", err, c_out);
    do_reset();

    // Randomized decodes against the model
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 59) == 0) begin
        do_reset();
        $display("rnd %0d reset", i);
        continue;
      end
      if ($urandom_range(0, 9) == 0) d = 8'($urandom);
      else d = 8'h01 << $urandom_range(0, 7);
      sa = 8'($urandom);
      sb = 8'($urandom);
      step(d, sa, sb);
      model_step(d, sa, sb);
      $display("rnd %0d dec=%02h A=%02h B=%02h C=%0h E=%0b done=%0b err=%0b",
               i, d, a_out, b_out, c_out, E, done, err);
      chk_all($sformatf("rnd%0d", i), 8'(ma), 8'(mb), 4'(mc), me[0], md[0], merr[0]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
